vga_timing_ctrl: RTL and testbench

//  Sequencer for the VGA display datapath. Divides the system clock into a pixel strobe.

---
 rtl/vga_timing_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_vga_timing_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA raster timing generator.
// Divides the system clock into a pixel strobe, tracks the current pixel
// position and runs horizontal/vertical phase FSMs (visible, front porch,
// sync, back porch). hsync, vsync, display_on, hpos/vpos and the line/frame
// strobes are all registered in the same clock, so they stay mutually aligned.
// Optional build macro VGA_FRAME_COUNTER_EN adds an 8-bit frame counter output
// (frame_cnt) that steps in the clock where frame_start is asserted.
module vga_timing_ctrl #(
   parameter int CLK_DIV   = 2,
   parameter int H_DISPLAY = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_DISPLAY = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter int SYNC_POL  = 0,
   parameter int X_W       = 10,
   parameter int Y_W       = 10
) (
   input  logic           clk,
   input  logic           reset_n,
   output logic           pixel_en,
   output logic           hsync,
   output logic           vsync,
   output logic           display_on,
   output logic [X_W-1:0] hpos,
   output logic [Y_W-1:0] vpos,
   output logic           line_start,
   output logic           frame_start
`ifdef VGA_FRAME_COUNTER_EN
   ,
   output logic [7:0]     frame_cnt
`endif
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   // Horizontal phase boundaries: the pixel column where each phase begins.
   localparam logic [X_W-1:0] H_LAST     = X_W'(H_TOTAL - 1);
   localparam logic [X_W-1:0] H_FP_BEGIN = X_W'(H_DISPLAY);
   localparam logic [X_W-1:0] H_SY_BEGIN = X_W'(H_DISPLAY + H_FRONT);
   localparam logic [X_W-1:0] H_BP_BEGIN = X_W'(H_DISPLAY + H_FRONT + H_SYNC);

   // Vertical phase boundaries: the line where each phase begins.
   localparam logic [Y_W-1:0] V_LAST     = Y_W'(V_TOTAL - 1);
   localparam logic [Y_W-1:0] V_FP_BEGIN = Y_W'(V_DISPLAY);
   localparam logic [Y_W-1:0] V_SY_BEGIN = Y_W'(V_DISPLAY + V_FRONT);
   localparam logic [Y_W-1:0] V_BP_BEGIN = Y_W'(V_DISPLAY + V_FRONT + V_SYNC);

   localparam logic SYNC_ON  = (SYNC_POL != 0);
   localparam logic SYNC_OFF = ~SYNC_ON;

   typedef enum logic [1:0] {
      PH_VIS  = 2'd0,
      PH_FP   = 2'd1,
      PH_SYNC = 2'd2,
      PH_BP   = 2'd3
   } phase_e;

   // Divider and position counters
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [X_W-1:0]   hpos_q, hpos_d;
   logic [Y_W-1:0]   vpos_q, vpos_d;
   logic             tick;
   logic             line_wrap;

   // Phase FSMs
   phase_e h_state_q, h_state_d;
   phase_e v_state_q, v_state_d;

   // Registered outputs
   logic pixel_en_q;
   logic hsync_q, hsync_d;
   logic vsync_q, vsync_d;
   logic display_on_q, display_on_d;
   logic line_start_q, line_start_d;
   logic frame_start_q, frame_start_d;

   // Pixel divider and raster position next-state.
   always_comb begin
      // NOTE: every signal written here gets a default first so no path
      // leaves it unassigned; otherwise synthesis infers a latch.
      tick      = (div_cnt_q == DIV_LAST);
      div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
      line_wrap = tick && (hpos_q == H_LAST);
      hpos_d    = hpos_q;
      vpos_d    = vpos_q;
      if (tick) begin
         hpos_d = (hpos_q == H_LAST) ? '0 : hpos_q + 1'b1;
      end
      if (line_wrap) begin
         vpos_d = (vpos_q == V_LAST) ? '0 : vpos_q + 1'b1;
      end
   end

   // Phase FSM next-state: H advances on pixel ticks, V only on line wrap.
   always_comb begin
      h_state_d = h_state_q;
      v_state_d = v_state_q;
      if (tick) begin
         case (h_state_q)
            PH_VIS:  if (hpos_d == H_FP_BEGIN) h_state_d = PH_FP;
            PH_FP:   if (hpos_d == H_SY_BEGIN) h_state_d = PH_SYNC;
            PH_SYNC: if (hpos_d == H_BP_BEGIN) h_state_d = PH_BP;
            PH_BP:   if (hpos_d == '0)         h_state_d = PH_VIS;
         endcase
      end
      if (line_wrap) begin
         case (v_state_q)
            PH_VIS:  if (vpos_d == V_FP_BEGIN) v_state_d = PH_FP;
            PH_FP:   if (vpos_d == V_SY_BEGIN) v_state_d = PH_SYNC;
            PH_SYNC: if (vpos_d == V_BP_BEGIN) v_state_d = PH_BP;
            PH_BP:   if (vpos_d == '0)         v_state_d = PH_VIS;
         endcase
      end
   end

   // Output decode from next-state values so outputs land with hpos/vpos.
   always_comb begin
      hsync_d       = (h_state_d == PH_SYNC) ? SYNC_ON : SYNC_OFF;
      vsync_d       = (v_state_d == PH_SYNC) ? SYNC_ON : SYNC_OFF;
      display_on_d  = (h_state_d == PH_VIS) && (v_state_d == PH_VIS);
      line_start_d  = tick && (hpos_d == '0);
      frame_start_d = line_start_d && (vpos_d == '0);
   end

   // State register: divider, position and both phase FSMs.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: reset sits in the sensitivity list, so it acts immediately;
      // position restarts at the last pixel so the first tick lands on (0,0).
      if (!reset_n) begin
         div_cnt_q <= '0;
         hpos_q    <= H_LAST;
         vpos_q    <= V_LAST;
         h_state_q <= PH_BP;
         v_state_q <= PH_BP;
      end else begin
         // NOTE: non-blocking assignments, so every register samples the
         // values from before this edge regardless of statement order.
         div_cnt_q <= div_cnt_d;
         hpos_q    <= hpos_d;
         vpos_q    <= vpos_d;
         h_state_q <= h_state_d;
         v_state_q <= v_state_d;
      end
   end

   // Output registers; decoded values only change on ticks, so they hold between.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pixel_en_q    <= 1'b0;
         hsync_q       <= SYNC_OFF;
         vsync_q       <= SYNC_OFF;
         display_on_q  <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         pixel_en_q    <= tick;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         display_on_q  <= display_on_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

`ifdef VGA_FRAME_COUNTER_EN
   logic [7:0] frame_cnt_q;

   // Frame counter, steps together with the frame_start strobe.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_cnt_q <= 8'd0;
      end else if (frame_start_d) begin
         frame_cnt_q <= frame_cnt_q + 8'd1;
      end
   end

   assign frame_cnt = frame_cnt_q;
`endif

   assign pixel_en    = pixel_en_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign display_on  = display_on_q;
   assign hpos        = hpos_q;
   assign vpos        = vpos_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: self-checking bench for vga_timing_ctrl.
// Three instances share one clock and reset: default 640x480 timing, a small
// CLK_DIV=2 raster and a tiny CLK_DIV=1 raster with active-high sync.
// A position-based reference model queues the expected outputs of every
// instance at each rising edge; a checker pops and compares at the falling
// edge. Directed steps cover first-tick latency, line timing, mid-frame reset
// and (with VGA_FRAME_COUNTER_EN) the frame counter wrap.
module tb_vga_timing_ctrl;

   typedef struct packed {
      logic       pe;
      logic       hs;
      logic       vs;
      logic       de;
      logic       ls;
      logic       fs;
      logic [9:0] h;
      logic [9:0] v;
      logic [7:0] fc;
   } obs_t;

   typedef struct packed {
      int         dv;
      int         h;
      int         v;
      logic       pe;
      logic       ls;
      logic       fs;
      logic [7:0] fc;
   } mstate_t;

   // Per-instance timing: 0 = defaults, 1 = small raster, 2 = tiny raster.
   localparam int P_DIV [3] = '{2, 2, 1};
   localparam int P_HD  [3] = '{640, 16, 4};
   localparam int P_HF  [3] = '{16, 4, 1};
   localparam int P_HS  [3] = '{96, 6, 2};
   localparam int P_HB  [3] = '{48, 6, 1};
   localparam int P_VD  [3] = '{480, 8, 2};
   localparam int P_VF  [3] = '{10, 2, 1};
   localparam int P_VS  [3] = '{2, 2, 1};
   localparam int P_VB  [3] = '{33, 3, 1};
   localparam int P_POL [3] = '{0, 0, 1};

   logic clk = 1'b0;
   logic reset_n;

   always #10 clk = ~clk;

   logic       pe0, hs0, vs0, de0, ls0, fs0;
   logic [9:0] h0, v0;
   logic [7:0] fc0;
   logic       pe1, hs1, vs1, de1, ls1, fs1;
   logic [4:0] h1;
   logic [3:0] v1;
   logic [7:0] fc1;
   logic       pe2, hs2, vs2, de2, ls2, fs2;
   logic [2:0] h2, v2;
   logic [7:0] fc2;

`ifndef VGA_FRAME_COUNTER_EN
   assign fc0 = 8'd0;
   assign fc1 = 8'd0;
   assign fc2 = 8'd0;
`endif

   vga_timing_ctrl u_def (
      .clk(clk), .reset_n(reset_n), .pixel_en(pe0), .hsync(hs0), .vsync(vs0),
      .display_on(de0), .hpos(h0), .vpos(v0), .line_start(ls0), .frame_start(fs0)
`ifdef VGA_FRAME_COUNTER_EN
      , .frame_cnt(fc0)
`endif
   );

   vga_timing_ctrl #(
      .CLK_DIV(2), .H_DISPLAY(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
      .V_DISPLAY(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_POL(0),
      .X_W(5), .Y_W(4)
   ) u_a (
      .clk(clk), .reset_n(reset_n), .pixel_en(pe1), .hsync(hs1), .vsync(vs1),
      .display_on(de1), .hpos(h1), .vpos(v1), .line_start(ls1), .frame_start(fs1)
`ifdef VGA_FRAME_COUNTER_EN
      , .frame_cnt(fc1)
`endif
   );

   vga_timing_ctrl #(
      .CLK_DIV(1), .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
      .V_DISPLAY(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_POL(1),
      .X_W(3), .Y_W(3)
   ) u_b (
      .clk(clk), .reset_n(reset_n), .pixel_en(pe2), .hsync(hs2), .vsync(vs2),
      .display_on(de2), .hpos(h2), .vpos(v2), .line_start(ls2), .frame_start(fs2)
`ifdef VGA_FRAME_COUNTER_EN
      , .frame_cnt(fc2)
`endif
   );

   obs_t act [3];

   always_comb begin
      act[0] = {pe0, hs0, vs0, de0, ls0, fs0, h0, v0, fc0};
      act[1] = {pe1, hs1, vs1, de1, ls1, fs1, 10'(h1), 10'(v1), fc1};
      act[2] = {pe2, hs2, vs2, de2, ls2, fs2, 10'(h2), 10'(v2), fc2};
   end

   int n_cmp = 0;
   int n_err = 0;

   mstate_t ms [3];
   obs_t    sbq [3][$];

   function automatic int phase(int p, int d, int f, int s);
      if (p < d) return 0;
      if (p < d + f) return 1;
      if (p < d + f + s) return 2;
      return 3;
   endfunction

   function automatic int h_total(int i);
      return P_HD[i] + P_HF[i] + P_HS[i] + P_HB[i];
   endfunction

   function automatic int v_total(int i);
      return P_VD[i] + P_VF[i] + P_VS[i] + P_VB[i];
   endfunction

   function automatic obs_t m_obs(mstate_t s, int i);
      obs_t o;
      int   hp, vp;
      hp   = phase(s.h, P_HD[i], P_HF[i], P_HS[i]);
      vp   = phase(s.v, P_VD[i], P_VF[i], P_VS[i]);
      o.pe = s.pe;
      o.hs = (hp == 2) ? (P_POL[i] != 0) : (P_POL[i] == 0);
      o.vs = (vp == 2) ? (P_POL[i] != 0) : (P_POL[i] == 0);
      o.de = (hp == 0) && (vp == 0);
      o.ls = s.ls;
      o.fs = s.fs;
      o.h  = 10'(s.h);
      o.v  = 10'(s.v);
`ifdef VGA_FRAME_COUNTER_EN
      o.fc = s.fc;
`else
      o.fc = 8'd0;
`endif
      return o;
   endfunction

   // Reference model: advance each raster on the rising edge, queue expectations.
   initial forever begin
      mstate_t s;
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         s = ms[i];
         if (!reset_n) begin
            s.dv = 0;
            s.h  = h_total(i) - 1;
            s.v  = v_total(i) - 1;
            s.pe = 1'b0;
            s.ls = 1'b0;
            s.fs = 1'b0;
            s.fc = 8'd0;
         end else if (s.dv == P_DIV[i] - 1) begin
            s.dv = 0;
            s.pe = 1'b1;
            if (s.h == h_total(i) - 1) begin
               s.h = 0;
               s.v = (s.v == v_total(i) - 1) ? 0 : s.v + 1;
            end else begin
               s.h = s.h + 1;
            end
            s.ls = (s.h == 0);
            s.fs = (s.h == 0) && (s.v == 0);
            if (s.fs) s.fc = s.fc + 8'd1;
         end else begin
            s.dv = s.dv + 1;
            s.pe = 1'b0;
            s.ls = 1'b0;
            s.fs = 1'b0;
         end
         ms[i] = s;
         sbq[i].push_back(m_obs(s, i));
      end
   end

   // Checker: compare outputs and FSM phases on the falling edge.
   initial forever begin
      obs_t e;
      int   st_obs [3];
      int   st_exp;
      @(negedge clk);
      st_obs[0] = int'(u_def.h_state_q) * 4 + int'(u_def.v_state_q);
      st_obs[1] = int'(u_a.h_state_q) * 4 + int'(u_a.v_state_q);
      st_obs[2] = int'(u_b.h_state_q) * 4 + int'(u_b.v_state_q);
      for (int i = 0; i < 3; i++) begin
         if (sbq[i].size() > 0) begin
            e = sbq[i].pop_front();
            n_cmp++;
            assert (act[i] === e) else begin
               n_err++;
               $error("FAIL sb_out%0d t=%0t observed=%h expected=%h", i, $time, act[i], e);
            end
            st_exp = phase(ms[i].h, P_HD[i], P_HF[i], P_HS[i]) * 4
                   + phase(ms[i].v, P_VD[i], P_VF[i], P_VS[i]);
            n_cmp++;
            assert (st_obs[i] === st_exp) else begin
               n_err++;
               $error("FAIL fsm_phase%0d t=%0t observed=%0d expected=%0d", i, $time, st_obs[i], st_exp);
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Directed sequence.
   initial begin
      int cnt, nb, fa1, fa2, vs_lo, de_bad;
      int t_de, h_de, t_hf, h_hf, t_hr, h_hr, t_ls;
      bit seen;

      // Reset state of the default instance.
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_hpos", 32'(h0), 799);
      check("rst_vpos", 32'(v0), 524);
      check("rst_hsync", 32'(hs0), 1);
      check("rst_vsync", 32'(vs0), 1);
      check("rst_display_on", 32'(de0), 0);
      check("rst_pixel_en", 32'(pe0), 0);
      check("rst_line_start", 32'(ls0), 0);
      check("rst_frame_start", 32'(fs0), 0);
      #1 reset_n = 1'b1;

      // First pixel: second rising edge after release.
      cnt  = 0;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk);
         cnt++;
         if (fs0) seen = 1'b1;
      end
      check("first_fs_edges", 32'(cnt), 2);
      check("first_pixel_en", 32'(pe0), 1);
      check("first_hpos", 32'(h0), 0);
      check("first_vpos", 32'(v0), 0);
      check("first_display_on", 32'(de0), 1);

      // One line of default timing, measured in clocks from frame_start.
      cnt  = 0;
      t_de = -1; h_de = -1; t_hf = -1; h_hf = -1; t_hr = -1; h_hr = -1; t_ls = -1;
      for (int k = 0; k < 1700 && t_ls < 0; k++) begin
         @(negedge clk);
         cnt++;
         if (t_de < 0 && !de0) begin t_de = cnt; h_de = int'(h0); end
         if (t_hf < 0 && !hs0) begin t_hf = cnt; h_hf = int'(h0); end
         if (t_hf >= 0 && t_hr < 0 && hs0) begin t_hr = cnt; h_hr = int'(h0); end
         if (t_ls < 0 && ls0) t_ls = cnt;
      end
      check("de_off_clk", 32'(t_de), 1280);
      check("de_off_hpos", 32'(h_de), 640);
      check("hsync_fall_clk", 32'(t_hf), 1312);
      check("hsync_fall_hpos", 32'(h_hf), 656);
      check("hsync_rise_clk", 32'(t_hr), 1504);
      check("hsync_rise_hpos", 32'(h_hr), 752);
      check("line_period", 32'(t_ls), 1600);
      check("line2_vpos", 32'(v0), 1);

      // Mid-frame reset on the small raster while its hsync is active.
      seen = 1'b0;
      for (int k = 0; k < 2000 && !seen; k++) begin
         @(negedge clk);
         if (h1 == 5'd23 && v1 == 4'd5) seen = 1'b1;
      end
      check("reach_mid_frame", 32'(seen), 1);
      check("pre_rst_hsync", 32'(hs1), 0);
      #1 reset_n = 1'b0;
      #1;
      check("mid_rst_hsync", 32'(hs1), 1);
      check("mid_rst_vsync", 32'(vs1), 1);
      check("mid_rst_display_on", 32'(de1), 0);
      check("mid_rst_hpos", 32'(h1), 31);
      check("mid_rst_vpos", 32'(v1), 14);
      check("mid_rst_pixel_en", 32'(pe1), 0);
      check("mid_rst_def_hsync", 32'(hs0), 1);
      check("mid_rst_b_hsync", 32'(hs2), 0);
      repeat (2) @(negedge clk);
      #1 reset_n = 1'b1;

      cnt  = 0;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk);
         cnt++;
         if (fs1) seen = 1'b1;
      end
      check("restart_fs_edges", 32'(cnt), 2);
      check("restart_hpos", 32'(h1), 0);
      check("restart_vpos", 32'(v1), 0);
      check("restart_display_on", 32'(de1), 1);
`ifdef VGA_FRAME_COUNTER_EN
      check("fcnt_first", 32'(fc2), 1);
`endif

      // Long run: 257 tiny-raster frames, small-raster frame period and vsync.
      cnt = 0; nb = 0; fa1 = -1; fa2 = -1; vs_lo = 0; de_bad = 0;
      for (int k = 0; k < 12000 && nb < 257; k++) begin
         @(negedge clk);
         cnt++;
         if (fs2) begin
            nb++;
`ifdef VGA_FRAME_COUNTER_EN
            check("fcnt_step", 32'(fc2), 32'((nb + 1) % 256));
`endif
         end
         if (fs1) begin
            if (fa1 < 0) fa1 = cnt;
            else if (fa2 < 0) fa2 = cnt;
         end
         if (fa1 >= 0 && fa2 < 0 && !vs1) vs_lo++;
         if (de1 && v1 >= 4'd8) de_bad++;
      end
      check("b_frames_seen", 32'(nb), 257);
      check("a_frame_period", 32'(fa2 - fa1), 960);
      check("a_vsync_low_clk", 32'(vs_lo), 128);
      check("a_de_outside", 32'(de_bad), 0);

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
